pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 16, payload width in bits (16 = one lc3b_word).
REQ-002 Parameter SKID, default 1; 1 = two-entry skid stage with registered in_ready, 0 = single-register stage with combinational in_ready.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous kill of every held entry.
REQ-006 in_valid  input  1  upstream presents a payload.
REQ-007 in_ready  output  1  stage accepts a payload this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  stage presents a payload downstream.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  WIDTH  downstream payload.
REQ-012 occupancy  output  2  number of held entries: 0, 1 or 2.

Function
REQ-013 An input transfer occurs when in_valid and in_ready are both 1 on a rising edge; an output transfer occurs when out_valid and out_ready are both 1 on a rising edge.
REQ-014 Payloads leave in acceptance order; none is lost, duplicated or reordered except by flush.
REQ-015 Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N, provided the stage was empty or drained at edge N.
REQ-016 SKID=1 states: EMPTY (occ 0), ONE (main register valid), TWO (main and skid registers valid).
REQ-017 SKID=1: in_ready = (state != TWO), driven from a register, with no combinational path from out_ready.
REQ-018 SKID=1 transitions from EMPTY: input transfer -> ONE with main <= in_data; otherwise stay in EMPTY.
REQ-019 SKID=1 transitions from ONE: input and output transfer -> ONE with main <= in_data; input transfer only -> TWO with skid <= in_data; output transfer only -> EMPTY; neither -> ONE.
REQ-020 SKID=1 transitions from TWO: output transfer -> ONE with main <= skid; otherwise stay in TWO.
REQ-021 out_valid = (state != EMPTY); out_data = main register; occupancy reflects the state.
REQ-022 SKID=0: one register; in_ready = !out_valid || out_ready (combinational); occupancy never exceeds 1.
REQ-023 flush=1: the next state is EMPTY regardless of the handshakes; any payload presented or accepted in that cycle is discarded; the data registers need not change.
REQ-024 A flush while in TWO also discards the skid entry; in_ready = 1 on the following cycle.
REQ-025 An output transfer in the flush cycle still counts as delivered downstream; the stage makes no further delivery of that payload.
REQ-026 out_data is stable while out_valid=1 and out_ready=0.
REQ-027 With in_valid=0, the stage drains at one payload per cycle while out_ready=1.

Reset
REQ-028 reset_n=0 asynchronously forces state EMPTY, out_valid=0, occupancy=0, out_data=0, and clears the main and skid registers to 0.
REQ-029 in_ready is 1 during and after reset in both modes; with SKID=1 the registered in_ready resets to 1.
REQ-030 Reset asserted mid-transfer discards all held payloads; the first edge after deassertion behaves as from EMPTY.

Structure
REQ-031 The state enumeration (EMPTY, ONE, TWO) is typedef lc3b_pipe_state in package lc3b_types; no other new package content.
REQ-032 The occupancy/state FSM is sub-module pipe_skid_ctrl, which outputs the load enables for main and skid; the data registers stay in pipe_stage.
REQ-033 SKID selects the implementation through a generate branch; unused skid storage is not instantiated when SKID=0.

Verification
REQ-034 SKID=1, WIDTH=16: after reset, push 0x1111, 0x2222, 0x3333 back-to-back with out_ready=1 -> same values out on consecutive cycles, 1-cycle latency, in_ready stays 1.
REQ-035 SKID=1: out_ready=0, push 0xAAAA then 0xBBBB -> occupancy=2 and in_ready=0; raise out_ready -> 0xAAAA then 0xBBBB delivered, occupancy 2->1->0.
REQ-036 SKID=1: state TWO, flush=1 with in_valid=1 and in_data=0xCCCC -> next cycle occupancy=0, out_valid=0, in_ready=1; 0xCCCC is never output.
REQ-037 SKID=0: out_valid=1 and out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 and in_data=0x0F0F -> replacement in one cycle, occupancy stays 1.
REQ-038 Assert reset_n=0 between clock edges while occupancy=2 -> out_valid=0 and out_data=0 immediately, before the next clock edge.
REQ-039 Random in_valid/out_ready for 10k cycles, WIDTH=32, both SKID values -> the scoreboard shows in-order, lossless delivery, and occupancy always equals the model count.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared type definitions for the LC-3b pipeline blocks.
package lc3b_types;

  // Occupancy of a pipeline stage: nothing held, main register held,
  // or main plus skid register held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } lc3b_pipe_state;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the two-entry skid stage. Produces the load enables for
// the main and skid data registers, plus a registered in_ready so no
// combinational path exists from out_ready back to in_ready.
// The current state is exported so the top level can derive out_valid and
// occupancy from it, and so checkers can observe it directly.
module pipe_skid_ctrl
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  input  logic           in_valid,
  input  logic           out_ready,
  output logic           in_ready,
  output lc3b_pipe_state state,
  output logic           load_main,
  output logic           load_skid,
  output logic           main_from_skid
);

  lc3b_pipe_state state_q;
  lc3b_pipe_state state_d;
  logic           in_ready_q;
  logic           in_xfer;
  logic           out_xfer;

  assign in_ready = in_ready_q;
  assign state    = state_q;
  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = (state_q != EMPTY) && out_ready;

  // Next-state and load-enable decode; flush overrides every handshake.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d        = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d        = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // State register; in_ready is precomputed from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage. A transfer happens on a rising edge where the
// producer's valid and the consumer's ready are both 1; valid never depends
// on ready, and payload/valid are held until the transfer completes.
// SKID=1 builds a two-entry skid buffer with registered in_ready;
// SKID=0 builds a single register with combinational in_ready.
module pipe_stage
  import lc3b_types::*;
#(
  parameter int WIDTH = 16,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_next;
  logic             main_load;

  assign out_data = main_q;

  // Main (output-facing) data register, shared by both implementations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
    end else if (main_load) begin
      main_q <= main_next;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      lc3b_pipe_state   state;
      logic             load_skid;
      logic             main_from_skid;
      logic [WIDTH-1:0] skid_q;

      pipe_skid_ctrl u_ctrl (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_ready       (in_ready),
        .state          (state),
        .load_main      (main_load),
        .load_skid      (load_skid),
        .main_from_skid (main_from_skid)
      );

      assign main_next = main_from_skid ? skid_q : in_data;
      assign out_valid = (state != EMPTY);

      // Skid register catches the payload accepted while the output stalls.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          skid_q <= '0;
        end else if (load_skid) begin
          skid_q <= in_data;
        end
      end

      // Occupancy is a direct decode of the FSM state.
      always_comb begin
        occupancy = 2'd0;
        case (state)
          ONE:     occupancy = 2'd1;
          TWO:     occupancy = 2'd2;
          default: occupancy = 2'd0;
        endcase
      end
    end else begin : g_single
      logic valid_q;
      logic in_xfer;
      logic out_xfer;

      assign in_ready  = !valid_q || out_ready;
      assign in_xfer   = in_valid && in_ready;
      assign out_xfer  = valid_q && out_ready;
      assign main_load = in_xfer && !flush;
      assign main_next = in_data;
      assign out_valid = valid_q;
      assign occupancy = {1'b0, valid_q};

      // Single valid bit: set on accept, cleared on drain or flush.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_q <= 1'b0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (in_xfer) begin
          valid_q <= 1'b1;
        end else if (out_xfer) begin
          valid_q <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: directed scenarios on a 16-bit skid stage and a
// 32-bit single-register stage, then randomized traffic on 32-bit instances
// of both variants compared against a queue-based reference model.
module tb_pipe_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // a: SKID=1 WIDTH=16 (directed)
  logic        a_fl, a_iv, a_ir, a_ov, a_or;
  logic [15:0] a_id, a_od;
  logic [1:0]  a_occ;
  // b: SKID=0 WIDTH=32 (directed + random)
  logic        b_fl, b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_id, b_od;
  logic [1:0]  b_occ;
  // c: SKID=1 WIDTH=32 (random)
  logic        c_fl, c_iv, c_ir, c_ov, c_or;
  logic [31:0] c_id, c_od;
  logic [1:0]  c_occ;

  pipe_stage #(.WIDTH(16), .SKID(1)) u_a (
    .clk(clk), .reset_n(rst_n), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .occupancy(a_occ));
  pipe_stage #(.WIDTH(32), .SKID(0)) u_b (
    .clk(clk), .reset_n(rst_n), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .occupancy(b_occ));
  pipe_stage #(.WIDTH(32), .SKID(1)) u_c (
    .clk(clk), .reset_n(rst_n), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir),
    .in_data(c_id), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
    .occupancy(c_occ));

  // ---------------- scoreboard ----------------
  logic [31:0] exp_b_q[$];
  logic [31:0] exp_c_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    a_iv = iv; a_id = d; a_or = ordy; a_fl = fl;
    #2;
  endtask

  task automatic set_b(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    b_iv = iv; b_id = d; b_or = ordy; b_fl = fl;
    #2;
  endtask

  task automatic idle_all();
    a_iv = 0; a_id = '0; a_or = 0; a_fl = 0;
    b_iv = 0; b_id = '0; b_or = 0; b_fl = 0;
    c_iv = 0; c_id = '0; c_or = 0; c_fl = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_ov"}, {31'd0, a_ov}, 32'd0);
    check({tag, "_a_od"}, {16'd0, a_od}, 32'd0);
    check({tag, "_a_occ"}, {30'd0, a_occ}, 32'd0);
    check({tag, "_a_ir"}, {31'd0, a_ir}, 32'd1);
    check({tag, "_b_ov"}, {31'd0, b_ov}, 32'd0);
    check({tag, "_b_ir"}, {31'd0, b_ir}, 32'd1);
    check({tag, "_c_occ"}, {30'd0, c_occ}, 32'd0);
    check({tag, "_c_ir"}, {31'd0, c_ir}, 32'd1);
  endtask

  // One random cycle for a single 32-bit DUT against its model queue.
  // The model: a FIFO of accepted payloads, capacity 2 for the skid stage,
  // 1 for the plain stage (which may accept while draining).
  task automatic model_expect(input string tag, input bit skid, input logic ov,
                              input logic ir, input logic [31:0] od, input logic [1:0] occ,
                              input logic iv, input logic ordy, input logic [31:0] q_head,
                              input int q_size, output bit out_x, output bit in_x);
    bit exp_ir;
    exp_ir = skid ? (q_size < 2) : ((q_size == 0) || ordy);
    check({tag, "_ov"}, {31'd0, ov}, {31'd0, q_size != 0});
    check({tag, "_occ"}, {30'd0, occ}, q_size[31:0]);
    check({tag, "_ir"}, {31'd0, ir}, {31'd0, exp_ir});
    if (q_size != 0) check({tag, "_od"}, od, q_head);
    out_x = (q_size != 0) && ordy;
    in_x  = iv && exp_ir;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit          bo, bi, co, ci, fl;
    logic [31:0] hb, hc;
    total = 0;
    bad   = 0;
    idle_all();
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    #3 rst_n = 1'b1;
    tick();

    // back-to-back stream, 1-cycle latency, in_ready held high
    set_a(1, 16'h1111, 1, 0);
    check("s34_ir0", {31'd0, a_ir}, 32'd1);
    check("s34_ov0", {31'd0, a_ov}, 32'd0);
    tick();
    set_a(1, 16'h2222, 1, 0);
    check("s34_od1", {16'd0, a_od}, 32'h1111);
    check("s34_ov1", {31'd0, a_ov}, 32'd1);
    check("s34_ir1", {31'd0, a_ir}, 32'd1);
    tick();
    set_a(1, 16'h3333, 1, 0);
    check("s34_od2", {16'd0, a_od}, 32'h2222);
    check("s34_ir2", {31'd0, a_ir}, 32'd1);
    tick();
    set_a(0, 16'h0000, 1, 0);
    check("s34_od3", {16'd0, a_od}, 32'h3333);
    check("s34_occ3", {30'd0, a_occ}, 32'd1);
    tick();
    #2;
    check("s34_empty", {31'd0, a_ov}, 32'd0);

    // fill to two entries under backpressure, then drain in order
    set_a(1, 16'hAAAA, 0, 0);
    tick();
    set_a(1, 16'hBBBB, 0, 0);
    check("s35_occ1", {30'd0, a_occ}, 32'd1);
    check("s35_ir1", {31'd0, a_ir}, 32'd1);
    tick();
    set_a(0, 16'h0000, 0, 0);
    check("s35_occ2", {30'd0, a_occ}, 32'd2);
    check("s35_ir2", {31'd0, a_ir}, 32'd0);
    check("s35_hold", {16'd0, a_od}, 32'hAAAA);
    tick();
    set_a(0, 16'h0000, 1, 0);
    check("s35_stable", {16'd0, a_od}, 32'hAAAA);
    check("s35_occ2b", {30'd0, a_occ}, 32'd2);
    tick();
    #2;
    check("s35_od_b", {16'd0, a_od}, 32'hBBBB);
    check("s35_occ_b", {30'd0, a_occ}, 32'd1);
    tick();
    #2;
    check("s35_occ0", {30'd0, a_occ}, 32'd0);
    check("s35_ov0", {31'd0, a_ov}, 32'd0);

    // flush while full, with a payload offered in the same cycle
    set_a(1, 16'h1234, 0, 0);
    tick();
    set_a(1, 16'h5678, 0, 0);
    tick();
    set_a(1, 16'hCCCC, 0, 1);
    check("s36_pre", {30'd0, a_occ}, 32'd2);
    tick();
    set_a(0, 16'h0000, 1, 0);
    check("s36_occ", {30'd0, a_occ}, 32'd0);
    check("s36_ov", {31'd0, a_ov}, 32'd0);
    check("s36_ir", {31'd0, a_ir}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      check("s36_no_cccc", {31'd0, a_ov}, 32'd0);
    end

    // single-register stage: combinational in_ready and one-cycle replacement
    set_b(1, 32'h0000_1234, 0, 0);
    check("s37_ir_empty", {31'd0, b_ir}, 32'd1);
    tick();
    set_b(1, 32'h0000_0F0F, 0, 0);
    check("s37_ov", {31'd0, b_ov}, 32'd1);
    check("s37_ir_stall", {31'd0, b_ir}, 32'd0);
    b_or = 1'b1;
    #1;
    check("s37_ir_comb", {31'd0, b_ir}, 32'd1);
    check("s37_od_old", b_od, 32'h0000_1234);
    tick();
    #2;
    check("s37_od_new", b_od, 32'h0000_0F0F);
    check("s37_occ", {30'd0, b_occ}, 32'd1);
    set_b(0, 32'h0, 1, 0);
    tick();
    #2;
    check("s37_drain", {30'd0, b_occ}, 32'd0);

    // asynchronous reset between edges while full
    set_a(1, 16'h4444, 0, 0);
    tick();
    set_a(1, 16'h5555, 0, 0);
    tick();
    set_a(0, 16'h0000, 0, 0);
    check("s38_full", {30'd0, a_occ}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("s38_ov", {31'd0, a_ov}, 32'd0);
    check("s38_od", {16'd0, a_od}, 32'd0);
    check("s38_occ", {30'd0, a_occ}, 32'd0);
    check("s38_ir", {31'd0, a_ir}, 32'd1);
    #2 rst_n = 1'b1;
    tick();
    set_a(1, 16'hDDDD, 1, 0);
    tick();
    set_a(0, 16'h0000, 1, 0);
    check("s38_after", {16'd0, a_od}, 32'hDDDD);
    check("s38_after_occ", {30'd0, a_occ}, 32'd1);

    // random traffic, both variants at WIDTH=32
    idle_all();
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    exp_b_q.delete();
    exp_c_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      fl   = ($urandom_range(0, 99) == 0);
      b_iv = $urandom_range(0, 1); b_or = $urandom_range(0, 1);
      b_id = $urandom; b_fl = fl;
      c_iv = $urandom_range(0, 1); c_or = $urandom_range(0, 1);
      c_id = $urandom; c_fl = fl;
      #2;
      hb = (exp_b_q.size() != 0) ? exp_b_q[0] : 32'd0;
      hc = (exp_c_q.size() != 0) ? exp_c_q[0] : 32'd0;
      model_expect("rnd_b", 1'b0, b_ov, b_ir, b_od, b_occ, b_iv, b_or, hb, exp_b_q.size(), bo, bi);
      model_expect("rnd_c", 1'b1, c_ov, c_ir, c_od, c_occ, c_iv, c_or, hc, exp_c_q.size(), co, ci);
      tick();
      if (bo) void'(exp_b_q.pop_front());
      if (co) void'(exp_c_q.pop_front());
      if (fl) begin
        exp_b_q.delete();
        exp_c_q.delete();
      end else begin
        if (bi) exp_b_q.push_back(b_id);
        if (ci) exp_c_q.push_back(c_id);
      end
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout: simulation did not complete, bad=%0d", bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
